// File: rtl/irq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : irq_ctrl_if
//  Description : Request/acknowledge bundle between interrupt sources, the
//                CPU side and the irq_ctrl priority interrupt controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface irq_ctrl_if #(
    parameter int N = 8
);
    localparam int c_vw = $clog2(N);

    logic [N-1:0]    IRQ;
    logic [N-1:0]    MASK;
    logic            WMASK;
    logic            INTA;
    logic            RTI;
    logic            REQI;
    logic [c_vw-1:0] VEC;
    logic [N-1:0]    PEND;
    logic [N-1:0]    INSRV;

    // Driving side: interrupt sources and the CPU
    modport master (
        output IRQ, MASK, WMASK, INTA, RTI,
        input  REQI, VEC, PEND, INSRV
    );

    // Controller side
    modport slave (
        input  IRQ, MASK, WMASK, INTA, RTI,
        output REQI, VEC, PEND, INSRV
    );
endinterface
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : irq_ctrl
//  Description : N-channel prioritised interrupt controller. Each request is
//                synchronised, glitch-filtered and edge-detected into PEND;
//                masked, priority-resolved against the in-service level and
//                presented to the CPU as REQI/VEC. INTA moves a channel from
//                pending to in service, RTI retires the highest-priority one.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_ctrl #(
    parameter int N    = 8,
    parameter int FILT = 2
) (
    input  logic       CLK,
    input  logic       RESET_N,
    irq_ctrl_if.slave  bus
);
    localparam int         c_vw       = $clog2(N);
    localparam logic [3:0] c_cnt_last = 4'(FILT - 1);

    logic [N-1:0]    r_sync1;
    logic [N-1:0]    r_sync2;
    logic [N-1:0]    r_mask;
    logic [N-1:0]    r_pend;
    logic [N-1:0]    r_insrv;
    logic            r_reqi;
    logic [c_vw-1:0] r_vec;

    logic [N-1:0]    w_filt;
    logic [N-1:0]    w_flip;
    logic [N-1:0]    w_rise;
    logic [N-1:0]    w_elig;
    logic [c_vw-1:0] w_vec;
    logic            w_ack;
    logic [N-1:0]    w_ack_bit;
    logic [N-1:0]    w_rti_bit;
    logic [N-1:0]    w_pend_nxt;
    logic [N-1:0]    w_insrv_nxt;

    // Two-flop synchroniser on every asynchronous request line
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.IRQ;
            r_sync2 <= r_sync1;
        end
    end

    // Per-channel debounce: the filtered level only follows the synchronised
    // input after FILT consecutive samples disagree with it.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_filt
            logic [3:0] r_cnt;
            logic       r_level;
            logic       w_diff;

            assign w_diff     = r_sync2[gi] ^ r_level;
            assign w_flip[gi] = w_diff && (r_cnt == c_cnt_last);
            assign w_filt[gi] = r_level;

            // Count disagreeing samples; any agreeing sample restarts the count
            always_ff @(posedge CLK or negedge RESET_N) begin
                if (!RESET_N) begin
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end else if (!w_diff) begin
                    r_cnt   <= '0;
                end else if (w_flip[gi]) begin
                    r_cnt   <= '0;
                    r_level <= r_sync2[gi];
                end else begin
                    r_cnt   <= r_cnt + 4'd1;
                end
            end
        end
    endgenerate

    // Rising edge of the filtered level, detected in the same cycle it flips
    // so the pending bit lands on the same edge as the filtered level.
    assign w_rise = w_flip & r_sync2;

    // A channel is eligible when pending, enabled, and strictly above the
    // current in-service level (no in-service bit at or below its index).
    always_comb begin : p_elig
        logic v_clear;
        v_clear = 1'b1;
        w_elig  = '0;
        for (int i = 0; i < N; i++) begin
            v_clear   = v_clear & ~r_insrv[i];
            w_elig[i] = r_pend[i] & r_mask[i] & v_clear;
        end
    end

    // Lowest-index eligible channel wins; zero when nothing is eligible
    always_comb begin
        w_vec = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_vec = c_vw'(i);
            end
        end
    end

    // Acknowledge only counts while a request is actually being presented
    assign w_ack       = bus.INTA & r_reqi;
    assign w_ack_bit   = w_ack ? (N'(1) << r_vec) : '0;
    // RTI retires the lowest set (highest priority) in-service bit
    assign w_rti_bit   = bus.RTI ? (r_insrv & (~r_insrv + N'(1))) : '0;
    // A new event on the channel being acknowledged survives the clear
    assign w_pend_nxt  = (r_pend & ~w_ack_bit) | w_rise;
    assign w_insrv_nxt = (r_insrv & ~w_rti_bit) | w_ack_bit;

    // Mask, pending/in-service bookkeeping and the registered CPU request
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_mask  <= '0;
            r_pend  <= '0;
            r_insrv <= '0;
            r_reqi  <= 1'b0;
            r_vec   <= '0;
        end else begin
            if (bus.WMASK) begin
                r_mask <= bus.MASK;
            end
            r_pend  <= w_pend_nxt;
            r_insrv <= w_insrv_nxt;
            r_reqi  <= |w_elig;
            r_vec   <= w_vec;
        end
    end

    assign bus.REQI  = r_reqi;
    assign bus.VEC   = r_vec;
    assign bus.PEND  = r_pend;
    assign bus.INSRV = r_insrv;

endmodule
`default_nettype wire
